spi_pad_arbiter: RTL and testbench
==================================

Name: spi_pad_arbiter

Overview:
- Arbitrates ownership of the single shared SPI/QSPI pad set between two masters: requester 0 (memory-mapped flash engine) and requester 1 (QSPI register engine).
- Grants the pads to one master at a time using round-robin on contention.
- Parks the pads in a safe state (CS deasserted, data undriven) for a programmable guard interval on every ownership change.
- Sits between both engines and the pad ring. It replaces ad-hoc switch-signal muxing with a sequenced handover.

Parameters:
- GUARD_CYC, 2, number of park cycles after each release; legal range 1..15.
- SCK_IDLE, 0, level driven on pad_sck while no master owns the pads (CPOL).
- STARVE_CYC, 256, cycles a non-owner may wait with its request pending before starve_flag sets; legal range 2..65535.

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous active-high reset
- m0_req  in  1  master 0 requests or holds ownership
- m0_gnt  out  1  master 0 owns the pads
- m0_sck  in  1  master 0 serial clock
- m0_csn  in  1  master 0 chip select, active low
- m0_dq_en  in  4  master 0 output enables for dq[3:0] (dq0=sdi, dq1=sdo, dq2=wpn, dq3=holdn)
- m0_dq_o  in  4  master 0 output data for dq[3:0]
- m1_req, m1_gnt, m1_sck, m1_csn, m1_dq_en, m1_dq_o: same as the master 0 set, for master 1
- m_dq_i  out  4  pad input data, fanned out unregistered to both masters
- pad_sck  out  1  pad serial clock
- pad_csn_en  out  1  chip-select output enable; constant 1
- pad_csn_o  out  1  pad chip select
- pad_dq_en  out  4  pad data output enables
- pad_dq_o  out  4  pad data outputs
- pad_dq_i  in  4  pad data inputs
- owner  out  2  {valid, id}: 2'b10 = m0, 2'b11 = m1, 2'b00 = none
- err_flag  out  1  sticky; a master dropped req while its csn was low
- starve_flag  out  1  sticky; a waiter exceeded STARVE_CYC
- flag_clr  in  1  clears both sticky flags

Behaviour:
- States are IDLE, GRANT, and GUARD. Registers: state, own_id, last_id, guard_cnt, starve_cnt, err_flag, starve_flag.
- Reset (areset sampled high at an aclk edge):
  - state=IDLE, m0_gnt=m1_gnt=0, owner=0, flags=0, guard_cnt=0, starve_cnt=0.
  - last_id=1, so master 0 wins the first tie.
  - Pads go to the parked state on the same edge.
  - Reset mid-GRANT drops the grant immediately; no guard interval is applied.
- Parked pad state (IDLE and GUARD):
  - pad_csn_o=1, pad_sck=SCK_IDLE, pad_dq_en=0, pad_dq_o=0.
- Owned pad state (GRANT): pad_sck, pad_csn_o, pad_dq_en and pad_dq_o are the owner's inputs, muxed combinationally from the registered own_id. No added latency.
- pad_csn_en is 1 at all times. m_dq_i = pad_dq_i at all times.
- IDLE:
  - Any req → GRANT on the next edge.
  - Winner: the single requester; or, if both request, the one with id != last_id.
  - The winner's gnt rises on that same edge (1-cycle latency from req to gnt).
- GRANT:
  - gnt stays high while owner req=1. The non-owner's req is ignored for arbitration.
  - Release happens when owner req=0 and owner csn=1 in the same cycle. On that edge: gnt falls, last_id=own_id, guard_cnt=GUARD_CYC-1, state goes to GUARD.
  - If owner req=0 while owner csn=0: stay in GRANT, set err_flag. Release completes on the first cycle with csn=1, even if req has since returned to 1 (the request was treated as dropped).
- GUARD:
  - Pads are parked; guard_cnt decrements each cycle.
  - When guard_cnt=0: if any req, go directly to GRANT using the IDLE arbitration rule; otherwise go to IDLE.
  - A single master re-requesting regains the pads after exactly GUARD_CYC park cycles.
- Starvation:
  - starve_cnt increments each cycle the non-owner's req=1 while state is not IDLE; it saturates at STARVE_CYC.
  - starve_flag sets when starve_cnt reaches STARVE_CYC.
  - starve_cnt clears whenever the waiter is granted or drops req.
  - The flag is status only. Ownership is never preempted.
- flag_clr: clears both sticky flags. If flag_clr and a set condition occur in the same cycle, set wins.
- Invariants: m0_gnt & m1_gnt is never 1. gnt is a registered output.

Decomposition:
- Shared package spi_pad_pkg holds:
  - state encoding ST_IDLE=2'd0, ST_GRANT=2'd1, ST_GUARD=2'd2;
  - the dq index constants DQ_SDI=0, DQ_SDO=1, DQ_WPN=2, DQ_HOLD=3;
  - the owner encoding constants.
- One natural sub-module, spi_pad_mux: purely combinational owner/park multiplexer for sck/csn/dq.
- The FSM, counters and flags stay in spi_pad_arbiter.

Test Plan:
- Reset then m0_req=1 at cycle 3 → m0_gnt=1 at cycle 4; pad_csn_o follows m0_csn; owner=2'b10.
- m0 and m1 req rise in the same cycle from reset → m0 granted (last_id=1). m0 releases with GUARD_CYC=2 → 2 parked cycles (pad_dq_en=0, pad_csn_o=1), then m1_gnt=1.
- m0 holds with m1 waiting; m0 releases then immediately re-requests → m1 granted after guard (round-robin); m0 granted only after m1 releases.
- m0 drops req while m0_csn=0 for 5 cycles → m0_gnt stays 1 and err_flag=1; release occurs on the first csn=1 cycle. flag_clr → err_flag=0.
- STARVE_CYC=8: m0 holds 20 cycles while m1 requests → starve_flag=1 after 8 waiting cycles; m0 is not preempted.
- areset asserted mid-GRANT → next edge m0_gnt=0, pads parked, state=IDLE; a subsequent m1_req is granted in 1 cycle with no guard.

Source files
------------

// File: rtl/spi_pad_pkg.sv
// Shared types and constants for the SPI pad arbiter: FSM encoding, dq lane
// indices, owner encoding and the round-robin pick helper.
package spi_pad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GUARD = 2'd2
  } state_e;

  localparam int DQ_SDI  = 0;
  localparam int DQ_SDO  = 1;
  localparam int DQ_WPN  = 2;
  localparam int DQ_HOLD = 3;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_M0   = 2'b10;
  localparam logic [1:0] OWNER_M1   = 2'b11;

  // On contention the master that did not own the pads last wins.
  function automatic logic arb_pick(input logic req0, input logic req1, input logic last_id);
    if (req0 && req1) return ~last_id;
    return req1;
  endfunction

  function automatic logic [1:0] owner_code(input logic valid, input logic id);
    if (!valid) return OWNER_NONE;
    return id ? OWNER_M1 : OWNER_M0;
  endfunction

endpackage

// File: rtl/spi_pad_arbiter_if.sv
// Engine-side bundle of the pad arbiter: request/grant handshake plus the
// pad-facing signals of both SPI engines.
interface spi_pad_arbiter_if;
  logic       m0_req;
  logic       m0_gnt;
  logic       m0_sck;
  logic       m0_csn;
  logic [3:0] m0_dq_en;
  logic [3:0] m0_dq_o;
  logic       m1_req;
  logic       m1_gnt;
  logic       m1_sck;
  logic       m1_csn;
  logic [3:0] m1_dq_en;
  logic [3:0] m1_dq_o;
  logic [3:0] m_dq_i;

  modport slave (
    input  m0_req, m0_sck, m0_csn, m0_dq_en, m0_dq_o,
    input  m1_req, m1_sck, m1_csn, m1_dq_en, m1_dq_o,
    output m0_gnt, m1_gnt, m_dq_i
  );

  modport master (
    output m0_req, m0_sck, m0_csn, m0_dq_en, m0_dq_o,
    output m1_req, m1_sck, m1_csn, m1_dq_en, m1_dq_o,
    input  m0_gnt, m1_gnt, m_dq_i
  );
endinterface

// File: rtl/spi_pad_mux.sv
// Combinational pad multiplexer: passes the owning engine straight through,
// otherwise holds the pads parked (CS high, clock idle, data undriven).
module spi_pad_mux #(
  parameter bit SCK_IDLE = 1'b0
) (
  input  logic       own_valid,
  input  logic       own_id,
  input  logic       m0_sck,
  input  logic       m0_csn,
  input  logic [3:0] m0_dq_en,
  input  logic [3:0] m0_dq_o,
  input  logic       m1_sck,
  input  logic       m1_csn,
  input  logic [3:0] m1_dq_en,
  input  logic [3:0] m1_dq_o,
  output logic       pad_sck,
  output logic       pad_csn_o,
  output logic [3:0] pad_dq_en,
  output logic [3:0] pad_dq_o
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned, which would infer a latch.
    pad_sck   = SCK_IDLE;
    pad_csn_o = 1'b1;
    pad_dq_en = 4'b0000;
    pad_dq_o  = 4'b0000;
    if (own_valid) begin
      if (own_id) begin
        pad_sck   = m1_sck;
        pad_csn_o = m1_csn;
        pad_dq_en = m1_dq_en;
        pad_dq_o  = m1_dq_o;
      end else begin
        pad_sck   = m0_sck;
        pad_csn_o = m0_csn;
        pad_dq_en = m0_dq_en;
        pad_dq_o  = m0_dq_o;
      end
    end
  end

endmodule

// File: rtl/spi_pad_arbiter.sv
// Round-robin owner of the shared SPI/QSPI pad set with a parked guard
// interval on every handover, plus sticky protocol-error and starvation flags.
module spi_pad_arbiter
  import spi_pad_pkg::*;
#(
  parameter int GUARD_CYC  = 2,
  parameter bit SCK_IDLE   = 1'b0,
  parameter int STARVE_CYC = 256
) (
  input  logic                  aclk,
  input  logic                  areset,
  spi_pad_arbiter_if.slave      eng,
  output logic                  pad_sck,
  output logic                  pad_csn_en,
  output logic                  pad_csn_o,
  output logic [3:0]            pad_dq_en,
  output logic [3:0]            pad_dq_o,
  input  logic [3:0]            pad_dq_i,
  output logic [1:0]            owner,
  output logic                  err_flag,
  output logic                  starve_flag,
  input  logic                  flag_clr
);

  localparam logic [3:0]  GUARD_INIT = 4'(GUARD_CYC - 1);
  localparam logic [15:0] STARVE_MAX = 16'(STARVE_CYC);

  state_e      state_q, state_d;
  logic        own_id_q, own_id_d;
  logic        last_id_q, last_id_d;
  logic        rel_pend_q, rel_pend_d;
  logic [3:0]  guard_cnt_q, guard_cnt_d;
  logic [15:0] starve_cnt_q, starve_cnt_d;
  logic        err_q, err_d;
  logic        starve_q, starve_d;
  logic        m0_gnt_q, m0_gnt_d;
  logic        m1_gnt_q, m1_gnt_d;
  logic [1:0]  owner_q, owner_d;

  logic own_req, own_csn, waiter_req, any_req, win_id;
  logic err_set, grant_waiter;

  always_comb begin
    own_req    = own_id_q ? eng.m1_req : eng.m0_req;
    own_csn    = own_id_q ? eng.m1_csn : eng.m0_csn;
    waiter_req = own_id_q ? eng.m0_req : eng.m1_req;
    any_req    = eng.m0_req | eng.m1_req;
    win_id     = arb_pick(eng.m0_req, eng.m1_req, last_id_q);

    state_d      = state_q;
    own_id_d     = own_id_q;
    last_id_d    = last_id_q;
    rel_pend_d   = rel_pend_q;
    guard_cnt_d  = guard_cnt_q;
    err_set      = 1'b0;
    grant_waiter = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d  = ST_GRANT;
          own_id_d = win_id;
        end
      end
      ST_GRANT: begin
        // A dropped request stays pending until CS is seen high, even if req returns.
        if ((rel_pend_q || !own_req) && own_csn) begin
          state_d     = ST_GUARD;
          last_id_d   = own_id_q;
          guard_cnt_d = GUARD_INIT;
          rel_pend_d  = 1'b0;
        end else if (!own_req) begin
          rel_pend_d = 1'b1;
          err_set    = 1'b1;
        end
      end
      ST_GUARD: begin
        if (guard_cnt_q == 4'd0) begin
          if (any_req) begin
            state_d      = ST_GRANT;
            own_id_d     = win_id;
            grant_waiter = (win_id != own_id_q);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          guard_cnt_d = guard_cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The waiter is always the master that does not hold (or did not last hold) the pads.
    if (state_q == ST_IDLE || !waiter_req || grant_waiter) begin
      starve_cnt_d = 16'd0;
    end else if (starve_cnt_q != STARVE_MAX) begin
      starve_cnt_d = starve_cnt_q + 16'd1;
    end else begin
      starve_cnt_d = starve_cnt_q;
    end

    err_d    = err_set | (err_q & ~flag_clr);
    starve_d = (starve_cnt_d == STARVE_MAX) | (starve_q & ~flag_clr);

    m0_gnt_d = (state_d == ST_GRANT) && !own_id_d;
    m1_gnt_d = (state_d == ST_GRANT) &&  own_id_d;
    owner_d  = owner_code(state_d == ST_GRANT, own_id_d);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= ST_IDLE;
      own_id_q     <= 1'b1;
      last_id_q    <= 1'b1;
      rel_pend_q   <= 1'b0;
      guard_cnt_q  <= 4'd0;
      starve_cnt_q <= 16'd0;
      err_q        <= 1'b0;
      starve_q     <= 1'b0;
      m0_gnt_q     <= 1'b0;
      m1_gnt_q     <= 1'b0;
      owner_q      <= OWNER_NONE;
    end else begin
      state_q      <= state_d;
      own_id_q     <= own_id_d;
      last_id_q    <= last_id_d;
      rel_pend_q   <= rel_pend_d;
      guard_cnt_q  <= guard_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      err_q        <= err_d;
      starve_q     <= starve_d;
      m0_gnt_q     <= m0_gnt_d;
      m1_gnt_q     <= m1_gnt_d;
      owner_q      <= owner_d;
    end
  end

  spi_pad_mux #(.SCK_IDLE(SCK_IDLE)) u_mux (
    .own_valid (state_q == ST_GRANT),
    .own_id    (own_id_q),
    .m0_sck    (eng.m0_sck),
    .m0_csn    (eng.m0_csn),
    .m0_dq_en  (eng.m0_dq_en),
    .m0_dq_o   (eng.m0_dq_o),
    .m1_sck    (eng.m1_sck),
    .m1_csn    (eng.m1_csn),
    .m1_dq_en  (eng.m1_dq_en),
    .m1_dq_o   (eng.m1_dq_o),
    .pad_sck   (pad_sck),
    .pad_csn_o (pad_csn_o),
    .pad_dq_en (pad_dq_en),
    .pad_dq_o  (pad_dq_o)
  );

  assign pad_csn_en  = 1'b1;
  assign eng.m_dq_i  = pad_dq_i;
  assign eng.m0_gnt  = m0_gnt_q;
  assign eng.m1_gnt  = m1_gnt_q;
  assign owner       = owner_q;
  assign err_flag    = err_q;
  assign starve_flag = starve_q;

endmodule

// File: tb/tb_spi_pad_arbiter.sv
// Self-checking bench for spi_pad_arbiter: directed handover scenarios with
// literal expectations, then randomized traffic against an ownership model.
module tb_spi_pad_arbiter;

  localparam int GUARD      = 2;
  localparam int STARVE     = 8;
  localparam bit SCK_IDLE_P = 1'b1;

  logic       clk = 1'b0;
  logic       areset;
  logic       pad_sck, pad_csn_en, pad_csn_o;
  logic [3:0] pad_dq_en, pad_dq_o, pad_dq_i;
  logic [1:0] owner;
  logic       err_flag, starve_flag, flag_clr;

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_en = 1'b0;

  spi_pad_arbiter_if bus ();

  spi_pad_arbiter #(.GUARD_CYC(GUARD), .SCK_IDLE(SCK_IDLE_P), .STARVE_CYC(STARVE)) dut (
    .aclk        (clk),
    .areset      (areset),
    .eng         (bus),
    .pad_sck     (pad_sck),
    .pad_csn_en  (pad_csn_en),
    .pad_csn_o   (pad_csn_o),
    .pad_dq_en   (pad_dq_en),
    .pad_dq_o    (pad_dq_o),
    .pad_dq_i    (pad_dq_i),
    .owner       (owner),
    .err_flag    (err_flag),
    .starve_flag (starve_flag),
    .flag_clr    (flag_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: dut=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic req_of(input int i);
    return (i == 1) ? bus.m1_req : bus.m0_req;
  endfunction

  function automatic logic csn_of(input int i);
    return (i == 1) ? bus.m1_csn : bus.m0_csn;
  endfunction

  // Ownership model: owner -1 = nobody, park = parked cycles still to come.
  int m_owner, m_park, m_last, m_wait;
  bit m_dropped, m_err, m_starve;
  int focus, waiter, granted;
  bit busy, err_set, rq0, rq1;

  always @(posedge clk) begin
    if (areset) begin
      m_owner = -1; m_park = 0; m_last = 1; m_wait = 0;
      m_dropped = 1'b0; m_err = 1'b0; m_starve = 1'b0;
    end else begin
      rq0     = bus.m0_req;
      rq1     = bus.m1_req;
      focus   = (m_owner >= 0) ? m_owner : m_last;
      busy    = (m_owner >= 0) || (m_park > 0);
      granted = -1;
      err_set = 1'b0;
      if (m_owner >= 0) begin
        if ((m_dropped || !req_of(m_owner)) && csn_of(m_owner)) begin
          m_last = m_owner; m_owner = -1; m_park = GUARD; m_dropped = 1'b0;
        end else if (!req_of(m_owner)) begin
          m_dropped = 1'b1; err_set = 1'b1;
        end
      end else begin
        if (m_park > 0) m_park--;
        if (m_park == 0 && (rq0 || rq1)) begin
          granted = (rq0 && rq1) ? 1 - m_last : (rq1 ? 1 : 0);
          m_owner = granted;
        end
      end
      waiter = 1 - focus;
      if (!busy || !req_of(waiter) || granted == waiter) m_wait = 0;
      else if (m_wait < STARVE) m_wait++;
      m_err    = err_set ? 1'b1 : (flag_clr ? 1'b0 : m_err);
      m_starve = (m_wait == STARVE) ? 1'b1 : (flag_clr ? 1'b0 : m_starve);
    end
  end

  logic [9:0] e_pad;
  logic [1:0] e_owner;

  always @(negedge clk) begin
    if (chk_en) begin
      if (m_owner == 0)      e_pad = {bus.m0_sck, bus.m0_csn, bus.m0_dq_en, bus.m0_dq_o};
      else if (m_owner == 1) e_pad = {bus.m1_sck, bus.m1_csn, bus.m1_dq_en, bus.m1_dq_o};
      else                   e_pad = {SCK_IDLE_P, 1'b1, 4'b0000, 4'b0000};
      e_owner = (m_owner < 0) ? 2'b00 : ((m_owner == 1) ? 2'b11 : 2'b10);
      check("gnt",    32'({bus.m0_gnt, bus.m1_gnt}), 32'({m_owner == 0, m_owner == 1}));
      check("owner",  32'(owner), 32'(e_owner));
      check("pads",   32'({pad_sck, pad_csn_o, pad_dq_en, pad_dq_o}), 32'(e_pad));
      check("flags",  32'({err_flag, starve_flag}), 32'({m_err, m_starve}));
      check("dq_in",  32'(bus.m_dq_i), 32'(pad_dq_i));
      check("csn_en", 32'(pad_csn_en), 32'd1);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic idle_inputs();
    bus.m0_req = 1'b0; bus.m0_sck = 1'b0; bus.m0_csn = 1'b1; bus.m0_dq_en = 4'h0; bus.m0_dq_o = 4'h0;
    bus.m1_req = 1'b0; bus.m1_sck = 1'b0; bus.m1_csn = 1'b1; bus.m1_dq_en = 4'h0; bus.m1_dq_o = 4'h0;
    pad_dq_i = 4'h0; flag_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    areset = 1'b1;
    step(1);
    areset = 1'b0;
  endtask

  initial begin
    idle_inputs();
    areset = 1'b1;
    step(2);
    chk_en = 1'b1;
    areset = 1'b0;

    // Reset state, then first grant with 1-cycle latency and pass-through.
    step(2);
    @(negedge clk);
    check("rst_owner", 32'(owner), 32'h0);
    check("rst_park", 32'({pad_sck, pad_csn_o, pad_dq_en}), 32'({SCK_IDLE_P, 1'b1, 4'h0}));
    check("rst_flags", 32'({err_flag, starve_flag}), 32'h0);
    bus.m0_req = 1'b1; bus.m0_csn = 1'b0; bus.m0_dq_en = 4'b1010; bus.m0_dq_o = 4'b0110;
    pad_dq_i = 4'b1001;
    #1 check("gnt_latency", 32'(bus.m0_gnt), 32'd0);
    step(1);
    @(negedge clk);
    check("m0_gnt", 32'({bus.m0_gnt, owner}), 32'({1'b1, 2'b10}));
    check("m0_pads", 32'({pad_sck, pad_csn_o, pad_dq_en, pad_dq_o}), 32'({1'b0, 1'b0, 4'b1010, 4'b0110}));
    check("m_dq_i", 32'(bus.m_dq_i), 32'h9);

    // Simultaneous first request: m0 wins, then m1 after two parked cycles.
    do_reset();
    bus.m0_req = 1'b1; bus.m1_req = 1'b1; bus.m1_csn = 1'b0; bus.m1_dq_en = 4'hF;
    step(1);
    @(negedge clk);
    check("tie_m0", 32'({bus.m0_gnt, bus.m1_gnt}), 32'b10);
    bus.m0_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1);
      @(negedge clk);
      check("guard_park", 32'({bus.m0_gnt, bus.m1_gnt, pad_csn_o, pad_dq_en}), 32'({1'b0, 1'b0, 1'b1, 4'h0}));
    end
    step(1);
    @(negedge clk);
    check("m1_after_guard", 32'({bus.m1_gnt, owner, pad_csn_o, pad_dq_en}), 32'({1'b1, 2'b11, 1'b0, 4'hF}));

    // Round-robin: a quick re-request by m0 loses to the waiting m1.
    do_reset();
    bus.m0_req = 1'b1;
    step(1);
    bus.m1_req = 1'b1;
    step(3);
    bus.m0_req = 1'b0;
    step(1);
    bus.m0_req = 1'b1;
    step(2);
    @(negedge clk);
    check("rr_m1", 32'({bus.m0_gnt, bus.m1_gnt}), 32'b01);
    step(3);
    bus.m1_req = 1'b0;
    step(3);
    @(negedge clk);
    check("rr_m0_back", 32'({bus.m0_gnt, bus.m1_gnt, starve_flag}), 32'b100);

    // Request dropped while CS is low: grant held, error flagged, then cleared.
    do_reset();
    bus.m0_req = 1'b1; bus.m0_csn = 1'b0;
    step(1);
    bus.m0_req = 1'b0;
    step(5);
    @(negedge clk);
    check("err_hold", 32'({bus.m0_gnt, err_flag}), 32'b11);
    bus.m0_req = 1'b1; bus.m0_csn = 1'b1;
    step(1);
    @(negedge clk);
    check("err_release", 32'(bus.m0_gnt), 32'd0);
    step(2);
    @(negedge clk);
    check("err_regrant", 32'(bus.m0_gnt), 32'd1);
    flag_clr = 1'b1;
    step(1);
    flag_clr = 1'b0;
    @(negedge clk);
    check("err_clr", 32'(err_flag), 32'd0);

    // Starvation flag after STARVE waiting cycles; no preemption.
    do_reset();
    bus.m0_req = 1'b1; bus.m0_csn = 1'b0;
    step(1);
    bus.m1_req = 1'b1;
    step(STARVE - 1);
    @(negedge clk);
    check("starve_pre", 32'(starve_flag), 32'd0);
    step(1);
    @(negedge clk);
    check("starve_set", 32'({starve_flag, bus.m0_gnt}), 32'b11);
    step(12);
    @(negedge clk);
    check("no_preempt", 32'({bus.m0_gnt, bus.m1_gnt}), 32'b10);
    bus.m0_req = 1'b0; bus.m0_csn = 1'b1;
    step(3);
    @(negedge clk);
    check("starve_m1", 32'(bus.m1_gnt), 32'd1);
    bus.m1_csn = 1'b0; bus.m1_req = 1'b0; flag_clr = 1'b1;
    step(1);
    flag_clr = 1'b0;
    @(negedge clk);
    check("set_wins", 32'({err_flag, starve_flag}), 32'b10);
    bus.m1_csn = 1'b1;
    step(1);

    // Reset mid-grant: immediate park, next request granted with no guard.
    do_reset();
    bus.m0_req = 1'b1; bus.m0_csn = 1'b0; bus.m0_dq_en = 4'hF;
    step(1);
    areset = 1'b1;
    step(1);
    @(negedge clk);
    check("rst_mid", 32'({bus.m0_gnt, owner, pad_csn_o, pad_dq_en}), 32'({1'b0, 2'b00, 1'b1, 4'h0}));
    areset = 1'b0; bus.m0_req = 1'b0; bus.m1_req = 1'b1;
    step(1);
    @(negedge clk);
    check("rst_then_m1", 32'(bus.m1_gnt), 32'd1);

    // Randomized traffic checked every cycle by the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (bus.m0_req) bus.m0_req = ($urandom_range(0, 15) != 0);
      else            bus.m0_req = ($urandom_range(0, 7) == 0);
      if (bus.m1_req) bus.m1_req = ($urandom_range(0, 15) != 0);
      else            bus.m1_req = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) bus.m0_csn = ~bus.m0_csn;
      if ($urandom_range(0, 3) == 0) bus.m1_csn = ~bus.m1_csn;
      bus.m0_sck   = 1'($urandom);
      bus.m1_sck   = 1'($urandom);
      bus.m0_dq_en = 4'($urandom);
      bus.m0_dq_o  = 4'($urandom);
      bus.m1_dq_en = 4'($urandom);
      bus.m1_dq_o  = 4'($urandom);
      pad_dq_i     = 4'($urandom);
      flag_clr     = ($urandom_range(0, 31) == 0);
      areset       = ($urandom_range(0, 499) == 0);
      step(1);
    end
    areset = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
